// File: rtl/sd_spi_phy_if.sv
// sd_spi_phy_if: engine-side bus of the SD SPI PHY (arbitration, byte handshake, receive data).
//   master modport: used by the requesting engines (init/read/write).
//   slave modport : used by sd_spi_phy.
//   ch_req/ch_gnt        per-channel request / one-hot grant
//   ch_tx_valid/_data    per-channel byte offer, byte i at [8*i+7:8*i]
//   ch_cs_high           per-channel: clock this byte with SD_CSn high
//   tx_ready             PHY accepts a byte from the granted channel
//   rx_valid/rx_data     1-cycle pulse with the byte just received
//   busy                 byte shift in progress
interface sd_spi_phy_if #(
    parameter int NUM_CH = 2
);
    logic [NUM_CH-1:0]   ch_req;
    logic [NUM_CH-1:0]   ch_gnt;
    logic [NUM_CH-1:0]   ch_tx_valid;
    logic [8*NUM_CH-1:0] ch_tx_data;
    logic [NUM_CH-1:0]   ch_cs_high;
    logic                tx_ready;
    logic                rx_valid;
    logic [7:0]          rx_data;
    logic                busy;

    modport master (
        output ch_req, ch_tx_valid, ch_tx_data, ch_cs_high,
        input  ch_gnt, tx_ready, rx_valid, rx_data, busy
    );

    modport slave (
        input  ch_req, ch_tx_valid, ch_tx_data, ch_cs_high,
        output ch_gnt, tx_ready, rx_valid, rx_data, busy
    );
endinterface

// File: rtl/sd_spi_phy.sv
// sd_spi_phy: SD-card SPI physical layer (mode 0, MSB first) with programmable SCLK
// divider and a round-robin arbiter letting NUM_CH engines share one card.
//   clk, rst      system clock, asynchronous active-high reset
//   speed_fast_i  0: CLK_DIV_INIT half-period, 1: CLK_DIV_FAST; sampled at byte handshake
//   sd_miso_i     card data out
//   sd_ck_o       SPI clock, idles low
//   sd_mosi_o     card data in, idles high
//   sd_csn_o      card select, active low
//   bus           engine-side interface (slave modport)
module sd_spi_phy #(
    parameter int CLK_DIV_INIT = 63,
    parameter int CLK_DIV_FAST = 0,
    parameter int DIV_W        = 8,
    parameter int NUM_CH       = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         speed_fast_i,
    input  logic         sd_miso_i,
    output logic         sd_ck_o,
    output logic         sd_mosi_o,
    output logic         sd_csn_o,
    sd_spi_phy_if.slave  bus
);
    localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [DIV_W-1:0] DIV_I = DIV_W'(CLK_DIV_INIT);
    localparam logic [DIV_W-1:0] DIV_F = DIV_W'(CLK_DIV_FAST);

    typedef enum logic [1:0] {IDLE, GRANT, XFER} state_t;

    state_t             state_q;
    logic [NUM_CH-1:0]  gnt_q;
    logic [PTR_W-1:0]   g_q, ptr_q, pick_d, idx;
    logic [DIV_W-1:0]   div_q, lim_q;
    logic [7:0]         sh_q, rx_sh_q, rx_data_q;
    logic [2:0]         bit_q;
    logic               tx_ready_q, rx_valid_q, busy_q, ck_q, mosi_q, csn_q, cs_low_q;

    // first requester at or after the round-robin pointer
    always_comb begin
        pick_d = '0;
        idx    = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            idx = PTR_W'((int'(ptr_q) + i) % NUM_CH);
            if (bus.ch_req[idx]) pick_d = idx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            g_q        <= '0;
            ptr_q      <= '0;
            div_q      <= '0;
            lim_q      <= '0;
            sh_q       <= '0;
            rx_sh_q    <= 8'hFF;
            rx_data_q  <= 8'hFF;
            bit_q      <= '0;
            tx_ready_q <= 1'b0;
            rx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            ck_q       <= 1'b0;
            mosi_q     <= 1'b1;
            csn_q      <= 1'b1;
            cs_low_q   <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            case (state_q)
                IDLE: if (|bus.ch_req) begin
                    state_q    <= GRANT;
                    g_q        <= pick_d;
                    gnt_q      <= NUM_CH'(1) << pick_d;
                    tx_ready_q <= 1'b1;
                end
                GRANT: if (!bus.ch_req[g_q]) begin
                    state_q    <= IDLE;
                    gnt_q      <= '0;
                    tx_ready_q <= 1'b0;
                    csn_q      <= 1'b1;
                    cs_low_q   <= 1'b0;
                    ptr_q      <= (g_q == PTR_W'(NUM_CH - 1)) ? '0 : g_q + 1'b1;
                end else if (bus.ch_tx_valid[g_q] && tx_ready_q) begin
                    state_q    <= XFER;
                    tx_ready_q <= 1'b0;
                    busy_q     <= 1'b1;
                    sh_q       <= bus.ch_tx_data[8*g_q +: 8];
                    mosi_q     <= bus.ch_tx_data[8*g_q + 7];
                    // a cs_high byte lifts CSn only for itself; cs_low_q remembers the owner's selection
                    csn_q      <= bus.ch_cs_high[g_q];
                    cs_low_q   <= cs_low_q | ~bus.ch_cs_high[g_q];
                    lim_q      <= speed_fast_i ? DIV_F : DIV_I;
                    div_q      <= '0;
                    bit_q      <= '0;
                end
                XFER: if (div_q != lim_q) begin
                    div_q <= div_q + 1'b1;
                end else begin
                    div_q <= '0;
                    ck_q  <= ~ck_q;
                    if (!ck_q) begin
                        rx_sh_q <= {rx_sh_q[6:0], sd_miso_i};
                    end else if (bit_q == 3'd7) begin
                        state_q    <= GRANT;
                        tx_ready_q <= 1'b1;
                        busy_q     <= 1'b0;
                        rx_valid_q <= 1'b1;
                        rx_data_q  <= rx_sh_q;
                        mosi_q     <= 1'b1;
                        csn_q      <= ~cs_low_q;
                    end else begin
                        sh_q   <= {sh_q[6:0], 1'b0};
                        mosi_q <= sh_q[6];
                        bit_q  <= bit_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.ch_gnt   = gnt_q;
    assign bus.tx_ready = tx_ready_q;
    assign bus.rx_valid = rx_valid_q;
    assign bus.rx_data  = rx_data_q;
    assign bus.busy     = busy_q;
    assign sd_ck_o      = ck_q;
    assign sd_mosi_o    = mosi_q;
    assign sd_csn_o     = csn_q;
endmodule
